// File: rtl/twofish_rs_sgen.sv
// Twofish key-schedule S-vector generator: Reed-Solomon 4x8 matrix over GF(2^8)/0x14D, one S word per key group.
// Build option TWOFISH_RS_BYTE_SERIAL_EN: 4 multipliers, one matrix column per cycle (8 cycles per word).
module twofish_rs_sgen #(
    parameter int KEY_W_MAX   = 256,
    parameter int S_WORDS_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                key_len,
    input  logic [KEY_W_MAX-1:0]      key_in,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2:0]                s_count,
    output logic [32*S_WORDS_MAX-1:0] s_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [63:0] RS_ROW0 = 64'h01A4_5587_5A58_DB9E;
    localparam logic [63:0] RS_ROW1 = 64'hA456_82F3_1EC6_68E5;
    localparam logic [63:0] RS_ROW2 = 64'h02A1_FCC1_47AE_3D19;
    localparam logic [63:0] RS_ROW3 = 64'hA455_875A_58DB_9E03;

`ifdef TWOFISH_RS_BYTE_SERIAL_EN
    localparam int KEY_STEP = 8;
`else
    localparam int KEY_STEP = 64;
`endif

    // Shift-and-add multiply in GF(2^8), reducing by x^8+x^6+x^3+x^2+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = aa[7] ? ((aa << 1) ^ 8'h4D) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rs_coef(input logic [1:0] row, input logic [2:0] col);
        logic [63:0] r;
        case (row)
            2'd0:    r = RS_ROW0;
            2'd1:    r = RS_ROW1;
            2'd2:    r = RS_ROW2;
            2'd3:    r = RS_ROW3;
            default: r = 64'h0;
        endcase
        return r[6'd56 - {col, 3'b000} +: 8];
    endfunction

    logic [1:0]                 state_r;
    logic [KEY_W_MAX-1:0]       key_r;
    logic [2:0]                 k_r;
    logic [2:0]                 idx_r;
    logic                       busy_r;
    logic                       out_valid_r;
    logic [2:0]                 s_count_r;
    logic [32*S_WORDS_MAX-1:0]  s_out_r;
    logic [2:0]                 k_s;
    logic [8:0]                 shamt_s;
    logic [31:0]                word_s;
    logic                       word_done_s;
`ifdef TWOFISH_RS_BYTE_SERIAL_EN
    logic [2:0]                 col_r;
    logic [31:0]                acc_r;
`endif

    // Decode key length into word count and the shift that left-justifies the key (m0 at the top byte).
    always_comb begin
        k_s     = 3'd4;
        shamt_s = 9'd0;
        case (key_len)
            2'b00:   begin k_s = 3'd2; shamt_s = 9'd128; end
            2'b01:   begin k_s = 3'd3; shamt_s = 9'd64;  end
            default: begin k_s = 3'd4; shamt_s = 9'd0;   end
        endcase
    end

`ifdef TWOFISH_RS_BYTE_SERIAL_EN
    // One matrix column per cycle: the current byte always sits at the top of key_r.
    always_comb begin
        word_s = acc_r;
        for (int i = 0; i < 4; i++) begin
            word_s[8*i +: 8] = acc_r[8*i +: 8] ^ gf_mul(rs_coef(2'(i), col_r), key_r[KEY_W_MAX-1 -: 8]);
        end
        if (col_r == 3'd7) begin
            word_done_s = 1'b1;
        end else begin
            word_done_s = 1'b0;
        end
    end
`else
    // Full matrix-vector product on the group at the top of key_r.
    always_comb begin
        word_s      = 32'h0;
        word_done_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 8; n++) begin
                word_s[8*i +: 8] = word_s[8*i +: 8]
                                 ^ gf_mul(rs_coef(2'(i), 3'(n)), key_r[KEY_W_MAX-1-8*n -: 8]);
            end
        end
    end
`endif

    // Control FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            key_r       <= '0;
            k_r         <= 3'd0;
            idx_r       <= 3'd0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            s_count_r   <= 3'd0;
            s_out_r     <= '0;
`ifdef TWOFISH_RS_BYTE_SERIAL_EN
            col_r       <= 3'd0;
            acc_r       <= 32'h0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        key_r   <= key_in << shamt_s;
                        k_r     <= k_s;
                        idx_r   <= 3'd0;
                        s_out_r <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_CALC;
`ifdef TWOFISH_RS_BYTE_SERIAL_EN
                        col_r   <= 3'd0;
                        acc_r   <= 32'h0;
`endif
                    end
                end
                ST_CALC: begin
                    key_r <= key_r << KEY_STEP;
`ifdef TWOFISH_RS_BYTE_SERIAL_EN
                    col_r <= col_r + 3'd1;
                    acc_r <= word_done_s ? 32'h0 : word_s;
`endif
                    if (word_done_s) begin
                        s_out_r[32*idx_r +: 32] <= word_s;
                        if (idx_r == k_r - 3'd1) begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                            s_count_r   <= k_r;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign s_count   = s_count_r;
    assign s_out     = s_out_r;

endmodule

// File: tb/tb_twofish_rs_sgen.sv
// Self-checking bench for twofish_rs_sgen: directed vectors plus random keys against a byte-level RS reference.
module tb_twofish_rs_sgen;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'b00;
    logic [255:0] key_in = 256'h0;
    logic         busy;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [2:0]   s_count;
    logic [127:0] s_out;

    int checks = 0;
    int errors = 0;
    logic [63:0] rs_rows [4];

    twofish_rs_sgen #(.KEY_W_MAX(256), .S_WORDS_MAX(4)) dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .s_count(s_count), .s_out(s_out)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Carry-less product then polynomial long division by 0x14D.
    function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int bitn = 14; bitn >= 8; bitn--)
            if (p[bitn]) p = p ^ (16'h014D << (bitn - 8));
        return p[7:0];
    endfunction

    function automatic int words_of(input logic [1:0] len);
        return (len == 2'b00) ? 2 : (len == 2'b01) ? 3 : 4;
    endfunction

    function automatic logic [127:0] model_s(input logic [255:0] key, input logic [1:0] len);
        logic [127:0] res;
        logic [7:0]   m [32];
        logic [7:0]   acc;
        int           k;
        int           nbytes;
        k      = words_of(len);
        nbytes = 8 * k;
        res    = 128'h0;
        for (int n = 0; n < nbytes; n++) m[n] = key[8*(nbytes-1-n) +: 8];
        for (int j = 0; j < k; j++)
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int n = 0; n < 8; n++)
                    acc = acc ^ gf_ref(rs_rows[i][8*(7-n) +: 8], m[8*j+n]);
                res[32*j + 8*i +: 8] = acc;
            end
        return res;
    endfunction

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_job(input logic [255:0] key, input logic [1:0] len, input int ready_delay,
                           input bit poke_start, input bit early_ready);
        logic [127:0] exp_s;
        int k;
        int lat;
        int c;
        k = words_of(len);
`ifdef TWOFISH_RS_BYTE_SERIAL_EN
        lat = 8 * k;
`else
        lat = k;
`endif
        exp_s   = model_s(key, len);
        key_in  = key;
        key_len = len;
        start   = 1'b1;
        step();
        start   = 1'b0;
        key_in  = rand_key();
        key_len = 2'($urandom_range(0, 3));
        check_value("busy_after_start", 128'(busy), 128'(1));
        out_ready = early_ready;
        c = 0;
        while (!out_valid && c < 200) begin
            start = poke_start && (c % 2 == 0);
            step();
            c++;
        end
        start = 1'b0;
        check_value("latency", 128'(c), 128'(lat));
        check_value("s_count", 128'(s_count), 128'(k));
        check_value("s_out", s_out, exp_s);
        if (early_ready) begin
            step();
            check_value("valid_drop_early", 128'(out_valid), 128'(0));
            check_value("busy_drop_early", 128'(busy), 128'(0));
            out_ready = 1'b0;
        end else begin
            for (int d = 0; d < ready_delay; d++) begin
                start = poke_start;
                step();
                check_value("valid_hold", 128'(out_valid), 128'(1));
                check_value("s_out_hold", s_out, exp_s);
            end
            out_ready = 1'b1;
            start     = poke_start;
            step();
            check_value("valid_drop", 128'(out_valid), 128'(0));
            check_value("busy_drop", 128'(busy), 128'(0));
            out_ready = 1'b0;
            start     = 1'b0;
            step();
            check_value("idle_after_done", 128'(busy), 128'(0));
            check_value("s_out_after_done", s_out, exp_s);
        end
    endtask

    initial begin
        logic [255:0] key;
        rs_rows[0] = 64'h01A4_5587_5A58_DB9E;
        rs_rows[1] = 64'hA456_82F3_1EC6_68E5;
        rs_rows[2] = 64'h02A1_FCC1_47AE_3D19;
        rs_rows[3] = 64'hA455_875A_58DB_9E03;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_value("rst_busy", 128'(busy), 128'(0));
        check_value("rst_valid", 128'(out_valid), 128'(0));
        check_value("rst_count", 128'(s_count), 128'(0));
        check_value("rst_s_out", s_out, 128'h0);

        run_job(256'h0, 2'b00, 0, 1'b0, 1'b0);
        check_value("zero_key", s_out, 128'h0);

        key = 256'h0; key[127:120] = 8'h01;
        run_job(key, 2'b00, 1, 1'b0, 1'b0);
        check_value("vec_a402a401", s_out, {64'h0, 32'h0, 32'hA402A401});

        key = 256'h0; key[119:112] = 8'h02;
        run_job(key, 2'b00, 0, 1'b0, 1'b0);
        check_value("vec_aa0fac05", s_out[31:0], 32'hAA0FAC05);

        key = 256'h0; key[71:64] = 8'h01;
        run_job(key, 2'b00, 0, 1'b0, 1'b0);
        check_value("vec_0319e59e", s_out[31:0], 32'h0319E59E);

        key = 256'h0; key[7:0] = 8'h01;
        run_job(key, 2'b10, 0, 1'b0, 1'b0);
        check_value("vec_256_word3", s_out, {32'h0319E59E, 96'h0});

        key = rand_key();
        run_job(key, 2'b01, 5, 1'b1, 1'b0);
        run_job(rand_key(), 2'b11, 0, 1'b0, 1'b1);

        // Abort a 192-bit job in the middle of CALC.
        key_in  = rand_key();
        key_len = 2'b01;
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_value("abort_busy", 128'(busy), 128'(0));
        check_value("abort_valid", 128'(out_valid), 128'(0));
        check_value("abort_count", 128'(s_count), 128'(0));
        check_value("abort_s_out", s_out, 128'h0);
        run_job(rand_key(), 2'b01, 0, 1'b0, 1'b0);

        for (int t = 0; t < 20; t++)
            run_job(rand_key(), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
